truth_table_pipe: RTL and testbench

- Streaming, parametrised truth-table evaluator for the signal-manipulation tasks.
- Each beat carries CHANNELS independent N_IN-bit input vectors. Each vector indexes a shared, run-time-loadable 2**N_IN-entry truth table.
- Output is one result bit per channel, delivered through a 2-stage valid/ready pipeline.
- A saturating counter tracks the number of '1' results delivered.

---
 rtl/ttp_pkg.sv | 15 +
 rtl/ttp_lut.sv | 10 +
 rtl/truth_table_pipe.sv | 84 ++++++++
 tb/tb_truth_table_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ttp_pkg.sv
// ttp_pkg: shared truth-table width helper, default table and popcount
package ttp_pkg;
  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction
  localparam int N_IN_DEF = 3;
  localparam int TT_W = tt_w(N_IN_DEF);
  localparam logic [TT_W-1:0] DEFAULT_TT = 8'b0011_1100;
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c += 7'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/ttp_lut.sv
// ttp_lut: combinational truth-table lookup of one N_IN-bit index
module ttp_lut #(
  parameter int N_IN = 3
) (
  input  logic [2**N_IN-1:0] tt,
  input  logic [N_IN-1:0]    idx,
  output logic               y
);
  assign y = tt[idx];
endmodule

// File: rtl/truth_table_pipe.sv
// truth_table_pipe: 2-stage valid/ready truth-table evaluator; TTP_PARITY_EN adds out_par
module truth_table_pipe
  import ttp_pkg::*;
#(
  parameter int                N_IN       = 3,
  parameter int                CHANNELS   = 1,
  parameter logic [2**N_IN-1:0] DEFAULT_TT = ttp_pkg::DEFAULT_TT,
  parameter int                CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     tt_load,
  input  logic [2**N_IN-1:0]       tt_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNELS*N_IN-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNELS-1:0]      out_data,
  output logic                     busy,
  output logic                     load_err,
`ifdef TTP_PARITY_EN
  output logic                     out_par,
`endif
  output logic [CNT_W-1:0]         ones_count
);
  localparam int TW = tt_w(N_IN);
  logic s1_valid, s2_valid, adv1, adv2, accept, load_ok;
  logic [CHANNELS*N_IN-1:0] s1_data;
  logic [TW-1:0] tt;
  logic [CHANNELS-1:0] lut_y;
  logic [CNT_W:0] sum;
  assign adv2 = !s2_valid | out_ready;
  assign adv1 = !s1_valid | adv2;
  assign in_ready = adv1 & !tt_load;
  assign accept = in_valid & in_ready;
  assign busy = s1_valid | s2_valid;
  assign out_valid = s2_valid;
  assign load_ok = tt_load & !busy;
  assign sum = {1'b0, ones_count} + (CNT_W+1)'(popcount(64'(out_data)));
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lut
    ttp_lut #(.N_IN(N_IN)) u_lut (.tt(tt), .idx(s1_data[k*N_IN +: N_IN]), .y(lut_y[k]));
  end
  // pipeline: stage 1 holds the input beat, stage 2 holds the lookup result
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= accept;
        if (accept) s1_data <= in_data;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) out_data <= lut_y;
      end
    end
  end
`ifdef TTP_PARITY_EN
  // parity travels with out_data through stage 2
  always_ff @(posedge clk) begin
    if (!n_reset) out_par <= 1'b0;
    else if (adv2 && s1_valid) out_par <= ^lut_y;
  end
`endif
  // table loads only when idle; delivered ones are counted with saturation
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tt <= DEFAULT_TT;
      ones_count <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= tt_load & busy;
      if (load_ok) begin
        tt <= tt_data;
        ones_count <= '0;
      end else if (out_valid && out_ready) begin
        ones_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_truth_table_pipe.sv
// tb_truth_table_pipe: scoreboard bench for truth_table_pipe (CHANNELS=2, CNT_W=4)
module tb_truth_table_pipe;
  logic clk = 0, n_reset = 0, tt_load = 0, in_valid = 0, out_ready = 1;
  logic [7:0] tt_data = '0;
  logic [5:0] in_data = '0;
  logic in_ready, out_valid, busy, load_err;
  logic [1:0] out_data;
  logic [3:0] ones_count;
  int total = 0, bad = 0, cyc = 0, om = 0;
  bit lat_on = 0;
  logic [7:0] tt_m = 8'b0011_1100;
  typedef struct {logic [1:0] d; int c;} beat_t;
  beat_t q[$];
  beat_t mb;

  truth_table_pipe #(.N_IN(3), .CHANNELS(2), .CNT_W(4)) dut (
    .clk(clk), .n_reset(n_reset), .tt_load(tt_load), .tt_data(tt_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .load_err(load_err), .ones_count(ones_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] model(input logic [5:0] d);
    return {tt_m[d[5:3]], tt_m[d[2:0]]};
  endfunction

  // monitor: pops expected beats on every delivered transfer and tracks the count model
  always @(negedge clk) begin
    if (!n_reset) begin
      q.delete();
      om = 0;
    end else begin
      if (tt_load && !busy) om = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("extra_beat", {30'b0, out_data}, 32'hffff_ffff);
        else begin
          mb = q.pop_front();
          check("data", {30'b0, out_data}, {30'b0, mb.d});
          if (lat_on) check("latency", cyc - mb.c, 2);
          om = om + $countones(out_data);
          if (om > 15) om = 15;
        end
      end
    end
  end

  task automatic send(input logic [5:0] d);
    int k;
    in_valid = 1;
    in_data = d;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k < 50) q.push_back('{model(d), cyc});
    else check("accept_timeout", k, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (q.size() != 0 || busy); k++) @(negedge clk);
    check("drain_q", q.size(), 0);
    check("drain_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] t, input bit exp_busy);
    bit was_busy;
    tt_load = 1;
    tt_data = t;
    @(negedge clk);
    was_busy = busy;
    check("busy_at_load", was_busy, exp_busy);
    check("in_ready_load", in_ready, 0);
    @(posedge clk); #1;
    tt_load = 0;
    if (!was_busy) tt_m = t;
    @(negedge clk);
    check("load_err", load_err, was_busy);
    @(negedge clk);
    check("load_err_clr", load_err, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] bp [3] = '{6'o23, 6'o54, 6'o71};
    logic [1:0] hold;
    bit have;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ones", ones_count, 0);
    check("rst_load_err", load_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    n_reset = 1;
    lat_on = 1;
    for (int i = 0; i < 8; i++) send({3'(7 - i), 3'(i)});
    drain();
    lat_on = 0;
    check("ones_stream", ones_count, 8);
    send(6'b010_101);
    send(6'b000_111);
    drain();
    check("ones_ch2", ones_count, om);
    out_ready = 0;
    in_valid = 1;
    n = 0;
    have = 0;
    in_data = bp[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{model(in_data), cyc});
        n++;
      end
      if (out_valid) begin
        if (!have) begin
          hold = out_data;
          have = 1;
        end else check("bp_stable", out_data, hold);
      end
      @(posedge clk); #1;
      in_data = bp[n];
    end
    check("bp_accepts", n, 2);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    drain();
    check("ones_bp", ones_count, om);
    send(6'o00);
    load(8'hff, 1);
    send(6'o07);
    drain();
    check("ones_busy_load", ones_count, om);
    load(8'h80, 0);
    check("ones_clr", ones_count, 0);
    send(6'o73);
    drain();
    check("ones_80", ones_count, 1);
    load(8'hff, 0);
    for (int i = 0; i < 10; i++) send(6'o12);
    drain();
    check("ones_sat", ones_count, 15);
    out_ready = 0;
    send(6'o00);
    send(6'o00);
    n_reset = 0;
    @(posedge clk); #1;
    n_reset = 1;
    tt_m = 8'b0011_1100;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ones", ones_count, 0);
    check("mid_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    send(6'o02);
    drain();
    check("ones_after_rst", ones_count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
